// File: rtl/seq_detect_1011.sv
// Serial 1-0-1-1 detector (overlapping) fed by an upstream flip-flop's Q.
// Moore FSM plus a 4-bit sample window and a saturating detection counter.
module seq_detect_1011 #(
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             CR,
    input  logic             EN,
    input  logic             D,
    output logic [3:0]       SR,
    output logic [2:0]       STATE,
    output logic             DET,
    output logic [CNT_W-1:0] CNT
);

    typedef enum logic [2:0] {
        S0 = 3'b000,
        S1 = 3'b001,
        S2 = 3'b010,
        S3 = 3'b011,
        S4 = 3'b100
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             legal;
    logic             hit;

    // Encodings 101..111 are not reachable but must recover even with EN low.
    assign legal = (state_q[2] == 1'b0) || (state_q[1:0] == 2'b00);
    assign hit   = EN && D && (state_q == S3);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S0:      state_d = D ? S1 : S0;
            S1:      state_d = D ? S1 : S2;
            S2:      state_d = D ? S3 : S0;
            S3:      state_d = D ? S4 : S2;
            S4:      state_d = D ? S1 : S2;
            default: state_d = S0;
        endcase
    end

    always_comb begin
        sr_d  = {sr_q[2:0], D};
        cnt_d = cnt_q;
        if (hit && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (CR) begin
            state_q <= S0;
            sr_q    <= 4'b0000;
            cnt_q   <= '0;
        end else begin
            if (EN || !legal) begin
                state_q <= state_d;
            end
            if (EN) begin
                sr_q  <= sr_d;
                cnt_q <= cnt_d;
            end
        end
    end

    assign SR    = sr_q;
    assign STATE = state_q;
    assign DET   = (state_q == S4);
    assign CNT   = cnt_q;

endmodule

// File: tb/tb_seq_detect_1011.sv
// Directed bench for seq_detect_1011: a default-width instance and a
// CNT_W=2 instance share the same stimulus so saturation can be observed.
module tb_seq_detect_1011;

    logic       CLK = 1'b0;
    logic       CR  = 1'b1;
    logic       EN  = 1'b0;
    logic       D   = 1'b0;
    logic [3:0] SR, SR_s;
    logic [2:0] STATE, STATE_s;
    logic       DET, DET_s;
    logic [3:0] CNT;
    logic [1:0] CNT_s;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    seq_detect_1011 #(.CNT_W(4)) dut (
        .CLK(CLK), .CR(CR), .EN(EN), .D(D),
        .SR(SR), .STATE(STATE), .DET(DET), .CNT(CNT)
    );

    seq_detect_1011 #(.CNT_W(2)) dut_sat (
        .CLK(CLK), .CR(CR), .EN(EN), .D(D),
        .SR(SR_s), .STATE(STATE_s), .DET(DET_s), .CNT(CNT_s)
    );

    // Inputs change on the falling edge; outputs are read 1 time unit after the rising edge.
    task automatic step(input logic cr, input logic en, input logic d);
        @(negedge CLK);
        CR = cr;
        EN = en;
        D  = d;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        step(1'b1, 1'b1, 1'b1);
    endtask

    // Feed one EN=1 bit and check state/DET afterwards.
    task automatic bit_in(input string tag, input logic d, input int exp_state, input int exp_det);
        step(1'b0, 1'b1, d);
        chk({tag, "_state"}, int'(STATE), exp_state);
        chk({tag, "_det"}, int'(DET), exp_det);
    endtask

    initial begin
        logic [3:0] en_seq, d_seq;
        int         st_seq [6];
        int         sr_seq [6];

        // Reset held two edges with D=1, EN=1
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        chk("rst_sr", int'(SR), 0);
        chk("rst_state", int'(STATE), 0);
        chk("rst_det", int'(DET), 0);
        chk("rst_cnt", int'(CNT), 0);
        chk("rst_cnt_sat", int'(CNT_s), 0);

        // Overlapping detection 1,0,1,1,0,1,1
        bit_in("ov1", 1'b1, 1, 0);
        bit_in("ov2", 1'b0, 2, 0);
        bit_in("ov3", 1'b1, 3, 0);
        bit_in("ov4", 1'b1, 4, 1);
        chk("ov4_cnt", int'(CNT), 1);
        bit_in("ov5", 1'b0, 2, 0);
        bit_in("ov6", 1'b1, 3, 0);
        bit_in("ov7", 1'b1, 4, 1);
        chk("ov_cnt", int'(CNT), 2);
        chk("ov_sr", int'(SR), 4'b1011);

        // Non-matching stream 1,1,0,0,1,0
        do_reset();
        bit_in("nm1", 1'b1, 1, 0);
        bit_in("nm2", 1'b1, 1, 0);
        bit_in("nm3", 1'b0, 2, 0);
        bit_in("nm4", 1'b0, 0, 0);
        bit_in("nm5", 1'b1, 1, 0);
        bit_in("nm6", 1'b0, 2, 0);
        chk("nm_cnt", int'(CNT), 0);
        chk("nm_sr", int'(SR), 4'b0010);

        // Same stream with EN low on alternate edges, starting from S2 / SR=0010
        en_seq = 4'b0101;
        d_seq  = 4'b0011;
        st_seq = '{3, 3, 2, 2, 3, 3};
        sr_seq = '{5, 5, 10, 10, 5, 5};
        for (int i = 0; i < 6; i++) begin
            logic [5:0] dv;
            dv = 6'b110010;
            step(1'b0, (i % 2) == 0, dv[5 - i]);
            chk($sformatf("gate%0d_state", i), int'(STATE), st_seq[i]);
            chk($sformatf("gate%0d_sr", i), int'(SR), sr_seq[i]);
            chk($sformatf("gate%0d_det", i), int'(DET), 0);
        end
        chk("gate_cnt", int'(CNT), 0);

        // Hold in S4 with EN low
        do_reset();
        bit_in("h1", 1'b1, 1, 0);
        bit_in("h2", 1'b0, 2, 0);
        bit_in("h3", 1'b1, 3, 0);
        bit_in("h4", 1'b1, 4, 1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, i[0]);
            chk($sformatf("hold%0d_det", i), int'(DET), 1);
            chk($sformatf("hold%0d_cnt", i), int'(CNT), 1);
            chk($sformatf("hold%0d_sr", i), int'(SR), 4'b1011);
        end
        bit_in("hx", 1'b0, 2, 0);
        chk("hx_cnt", int'(CNT), 1);

        // Saturation: four detections, CNT_W=2 stops at 3
        do_reset();
        bit_in("s1", 1'b1, 1, 0);
        bit_in("s2", 1'b0, 2, 0);
        bit_in("s3", 1'b1, 3, 0);
        bit_in("s4", 1'b1, 4, 1);
        chk("sat_d1", int'(CNT_s), 1);
        for (int k = 0; k < 3; k++) begin
            bit_in($sformatf("sr%0d_a", k), 1'b0, 2, 0);
            bit_in($sformatf("sr%0d_b", k), 1'b1, 3, 0);
            bit_in($sformatf("sr%0d_c", k), 1'b1, 4, 1);
            chk($sformatf("sat_d%0d", k + 2), int'(CNT_s), (k + 2 > 3) ? 3 : k + 2);
            chk($sformatf("wide_d%0d", k + 2), int'(CNT), k + 2);
        end
        step(1'b0, 1'b1, 1'b0);
        chk("sat_hold", int'(CNT_s), 3);

        // Reset mid-pattern, CR and EN high together
        do_reset();
        bit_in("m1", 1'b1, 1, 0);
        bit_in("m2", 1'b0, 2, 0);
        bit_in("m3", 1'b1, 3, 0);
        step(1'b1, 1'b1, 1'b1);
        chk("mr_state", int'(STATE), 0);
        chk("mr_sr", int'(SR), 0);
        chk("mr_det", int'(DET), 0);
        bit_in("m4", 1'b1, 1, 0);
        chk("m4_cnt", int'(CNT), 0);
        bit_in("m5", 1'b0, 2, 0);
        bit_in("m6", 1'b1, 3, 0);
        bit_in("m7", 1'b1, 4, 1);
        chk("m7_cnt", int'(CNT), 1);
        chk("m7_sr", int'(SR), 4'b1011);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
